// File: rtl/sdram_sequencer_if.sv
// 68k-side request signals and SDRAM pin bundle for sdram_sequencer.
interface sdram_sequencer_if;
   logic        AS;
   logic        RW;
   logic        UDS;
   logic        LDS;
   logic [22:0] A;
   logic        VALID;
   logic [12:0] MA;
   logic [1:0]  BA;
   logic [1:0]  DQM;
   logic        RAS;
   logic        CAS;
   logic        RAMWE;
   logic        CKE;
   logic        READY;

   modport master (output AS, RW, UDS, LDS, A,
                   input  VALID, MA, BA, DQM, RAS, CAS, RAMWE, CKE, READY);
   modport slave  (input  AS, RW, UDS, LDS, A,
                   output VALID, MA, BA, DQM, RAS, CAS, RAMWE, CKE, READY);
endinterface

// File: rtl/sdram_sequencer.sv
// SDRAM command sequencer: power-up init, auto-refresh arbitration and single-word
// 68k read/write accesses with auto-precharge. All pin outputs come straight from registers.
module sdram_sequencer #(
   parameter int INIT_WAIT    = 3200,
   parameter int REF_INTERVAL = 250,
   parameter int T_RCD        = 2,
   parameter int CAS_LAT      = 2,
   parameter int T_RP         = 2,
   parameter int T_RFC        = 7
) (
   input  logic             CLK,
   input  logic             RST,
   sdram_sequencer_if.slave io_bus
);
   localparam int C_PRE  = INIT_WAIT + 1;
   localparam int C_REF1 = C_PRE + T_RP;
   localparam int C_REF2 = C_REF1 + T_RFC;
   localparam int C_MRS  = C_REF2 + T_RFC;
   localparam int C_DONE = C_MRS + 2;
   localparam int TW     = $clog2(REF_INTERVAL);

   localparam logic [2:0] CMD_NOP = 3'b111;
   localparam logic [2:0] CMD_ACT = 3'b011;
   localparam logic [2:0] CMD_RD  = 3'b101;
   localparam logic [2:0] CMD_WR  = 3'b100;
   localparam logic [2:0] CMD_PRE = 3'b010;
   localparam logic [2:0] CMD_REF = 3'b001;
   localparam logic [2:0] CMD_MRS = 3'b000;

   typedef enum logic [2:0] {
      S_INIT = 3'd0,
      S_IDLE = 3'd1,
      S_ACT  = 3'd2,
      S_XFER = 3'd3,
      S_HOLD = 3'd4,
      S_REF  = 3'd5
   } state_t;

   state_t        r_state;
   logic [15:0]   r_cnt;
   logic [TW-1:0] r_ref_tmr;
   logic [1:0]    r_pending;
   logic [2:0]    r_cmd;
   logic          r_cke;
   logic          r_valid;
   logic          r_ready;
   logic [1:0]    r_dqm;
   logic [12:0]   r_ma;
   logic [1:0]    r_ba;
   logic [8:0]    r_col;
   logic          r_rd;
   logic          r_abort;

   logic [15:0]   w_cnt_inc;
   logic [15:0]   w_lat;
   logic          w_wrap;
   logic          w_ref_go;
   logic          w_abort_now;
   logic [1:0]    w_pending_nxt;

   // Cycle counter step, refresh-timer wrap, arbitration and pending-refresh bookkeeping.
   always_comb begin
      w_cnt_inc     = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
      w_lat         = r_rd ? 16'(CAS_LAT) : 16'd1;
      w_wrap        = r_ready && (r_ref_tmr == TW'(REF_INTERVAL - 1));
      // A wrap in the same cycle as an incoming AS already counts, so refresh wins the tie.
      w_ref_go      = (r_state == S_IDLE) && ((r_pending != 2'd0) || w_wrap);
      w_abort_now   = r_abort | io_bus.AS;
      w_pending_nxt = r_pending;
      case ({w_wrap, w_ref_go})
         2'b10:   w_pending_nxt = (r_pending == 2'd3) ? 2'd3 : r_pending + 2'd1;
         2'b01:   w_pending_nxt = r_pending - 2'd1;
         default: w_pending_nxt = r_pending;
      endcase
   end

   // Main sequencer FSM with registered command, address and status outputs.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state   <= S_INIT;
         r_cnt     <= 16'd0;
         r_ref_tmr <= {TW{1'b0}};
         r_pending <= 2'd0;
         r_cmd     <= CMD_NOP;
         r_cke     <= 1'b0;
         r_valid   <= 1'b1;
         r_ready   <= 1'b0;
         r_dqm     <= 2'b11;
         r_ma      <= 13'd0;
         r_ba      <= 2'd0;
         r_col     <= 9'd0;
         r_rd      <= 1'b0;
         r_abort   <= 1'b0;
      end else begin
         r_cmd     <= CMD_NOP;
         r_cnt     <= w_cnt_inc;
         r_pending <= w_pending_nxt;
         if (!r_ready || w_wrap) begin
            r_ref_tmr <= {TW{1'b0}};
         end else begin
            r_ref_tmr <= r_ref_tmr + TW'(1);
         end
         case (r_state)
            S_INIT: begin
               r_cke <= 1'b1;
               if (w_cnt_inc == 16'(C_PRE)) begin
                  r_cmd <= CMD_PRE;
                  r_ma  <= 13'h0400;
               end else if ((w_cnt_inc == 16'(C_REF1)) || (w_cnt_inc == 16'(C_REF2))) begin
                  r_cmd <= CMD_REF;
               end else if (w_cnt_inc == 16'(C_MRS)) begin
                  r_cmd <= CMD_MRS;
                  r_ma  <= 13'h0020;
                  r_ba  <= 2'b00;
               end else if (w_cnt_inc == 16'(C_DONE)) begin
                  r_ready <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            S_IDLE: begin
               r_cnt <= 16'd0;
               r_dqm <= 2'b11;
               if (w_ref_go) begin
                  r_cmd   <= CMD_REF;
                  r_state <= (T_RFC > 1) ? S_REF : S_IDLE;
               end else if (!io_bus.AS) begin
                  r_cmd   <= CMD_ACT;
                  r_ba    <= io_bus.A[10:9];
                  r_ma    <= {1'b0, io_bus.A[22:11]};
                  r_col   <= io_bus.A[8:0];
                  r_rd    <= io_bus.RW;
                  r_abort <= 1'b0;
                  r_state <= S_ACT;
               end
            end
            S_ACT: begin
               r_abort <= w_abort_now;
               if (w_cnt_inc == 16'(T_RCD)) begin
                  r_cmd   <= r_rd ? CMD_RD : CMD_WR;
                  // MA[10] set selects auto-precharge for the column command.
                  r_ma    <= {2'b00, 1'b1, 1'b0, r_col};
                  r_dqm   <= {io_bus.UDS, io_bus.LDS};
                  r_cnt   <= 16'd0;
                  r_state <= S_XFER;
               end
            end
            S_XFER: begin
               r_abort <= w_abort_now;
               if (!r_rd || (w_cnt_inc > 16'(CAS_LAT))) begin
                  r_dqm <= 2'b11;
               end
               if (!w_abort_now && (w_cnt_inc == w_lat)) begin
                  r_valid <= 1'b0;
                  r_state <= S_HOLD;
               end else if (w_abort_now && (w_cnt_inc >= 16'(T_RP))) begin
                  r_state <= S_IDLE;
               end
            end
            S_HOLD: begin
               r_dqm <= 2'b11;
               if (io_bus.AS) begin
                  r_valid <= 1'b1;
                  r_abort <= 1'b1;
                  r_state <= (w_cnt_inc >= 16'(T_RP)) ? S_IDLE : S_XFER;
               end
            end
            S_REF: begin
               if (w_cnt_inc >= 16'(T_RFC - 1)) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_INIT;
               r_cnt   <= 16'd0;
            end
         endcase
      end
   end

   assign io_bus.RAS   = r_cmd[2];
   assign io_bus.CAS   = r_cmd[1];
   assign io_bus.RAMWE = r_cmd[0];
   assign io_bus.MA    = r_ma;
   assign io_bus.BA    = r_ba;
   assign io_bus.DQM   = r_dqm;
   assign io_bus.CKE   = r_cke;
   assign io_bus.VALID = r_valid;
   assign io_bus.READY = r_ready;
endmodule

// File: tb/tb_sdram_sequencer.sv
// Directed bench for sdram_sequencer: vector table of single accesses plus
// hand-written init, refresh-tie, refresh-saturation, abort and reset sequences.
module tb_sdram_sequencer;
   localparam int INIT_WAIT    = 3200;
   localparam int REF_INTERVAL = 250;
   localparam int T_RCD        = 2;
   localparam int CAS_LAT      = 2;
   localparam int T_RP         = 2;
   localparam int T_RFC        = 7;

   localparam logic [2:0] CMD_NOP = 3'b111;
   localparam logic [2:0] CMD_ACT = 3'b011;
   localparam logic [2:0] CMD_RD  = 3'b101;
   localparam logic [2:0] CMD_WR  = 3'b100;
   localparam logic [2:0] CMD_PRE = 3'b010;
   localparam logic [2:0] CMD_REF = 3'b001;
   localparam logic [2:0] CMD_MRS = 3'b000;

   typedef struct {
      logic [22:0] a;
      logic        rw;
      logic        uds;
      logic        lds;
      int          hold;
      logic [1:0]  exp_ba;
      logic [12:0] exp_row;
      logic [12:0] exp_col;
      logic [2:0]  exp_cmd;
      logic [1:0]  exp_dqm;
      int          exp_lat;
   } vec_t;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   int          ev_ref, ev_act, ev_cmd, ev_valid;
   logic [12:0] ev_act_ma, ev_cmd_ma;
   logic [1:0]  ev_act_ba, ev_cmd_ba, ev_cmd_dqm, ev_vdqm;
   logic [2:0]  ev_cmd_c;
   logic        ev_hold_ok, ev_rel;

   sdram_sequencer_if bus ();

   sdram_sequencer #(
      .INIT_WAIT(INIT_WAIT), .REF_INTERVAL(REF_INTERVAL), .T_RCD(T_RCD),
      .CAS_LAT(CAS_LAT), .T_RP(T_RP), .T_RFC(T_RFC)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .io_bus(bus)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [2:0] cmd_now();
      return {bus.RAS, bus.CAS, bus.RAMWE};
   endfunction

   task automatic run_init();
      int t_pre, t_mrs, t_rdy, n_ref, n_other;
      int t_ref [2];
      logic pre_a10;
      logic [12:0] mrs_ma;
      logic [2:0] c;
      t_pre = -1; t_mrs = -1; n_ref = 0; n_other = 0;
      t_ref[0] = -1; t_ref[1] = -1; pre_a10 = 1'b0; mrs_ma = 13'd0;
      RST = 1'b0;
      bus.AS = 1'b1;
      tick();
      tick();
      chk("rst_cmd", 32'(cmd_now()), 32'(CMD_NOP));
      chk("rst_cke", 32'(bus.CKE), 32'd0);
      chk("rst_valid", 32'(bus.VALID), 32'd1);
      chk("rst_ready", 32'(bus.READY), 32'd0);
      chk("rst_dqm", 32'(bus.DQM), 32'd3);
      chk("rst_ma_ba", 32'({bus.MA, bus.BA}), 32'd0);
      RST = 1'b1;
      bus.AS = 1'b0;
      cyc = 0;
      tick();
      chk("init_cke", 32'(bus.CKE), 32'd1);
      while (!bus.READY && cyc < 4000) begin
         c = cmd_now();
         if (c == CMD_PRE) begin
            t_pre = cyc; pre_a10 = bus.MA[10];
         end else if (c == CMD_REF) begin
            if (n_ref < 2) t_ref[n_ref] = cyc;
            n_ref++;
         end else if (c == CMD_MRS) begin
            t_mrs = cyc; mrs_ma = bus.MA;
         end else if (c != CMD_NOP) begin
            n_other++;
         end
         tick();
      end
      t_rdy = bus.READY ? cyc : -1;
      bus.AS = 1'b1;
      chk("init_pre_cycle", 32'(t_pre), 32'(INIT_WAIT + 1));
      chk("init_pre_a10", 32'(pre_a10), 32'd1);
      chk("init_ref_count", 32'(n_ref), 32'd2);
      chk("init_ref1_cycle", 32'(t_ref[0]), 32'(INIT_WAIT + 1 + T_RP));
      chk("init_ref2_cycle", 32'(t_ref[1]), 32'(INIT_WAIT + 1 + T_RP + T_RFC));
      chk("init_mrs_cycle", 32'(t_mrs), 32'(INIT_WAIT + 1 + T_RP + 2 * T_RFC));
      chk("init_mrs_ma", 32'(mrs_ma), 32'h020);
      chk("init_ready_cycle", 32'(t_rdy), 32'(INIT_WAIT + 1 + T_RP + 2 * T_RFC + 2));
      chk("init_no_other_cmd", 32'(n_other), 32'd0);
   endtask

   task automatic access(input logic [22:0] a, input logic rw, input logic uds,
                         input logic lds, input int hold);
      logic [2:0] c;
      ev_ref = -1; ev_act = -1; ev_cmd = -1; ev_valid = -1; ev_hold_ok = 1'b1;
      bus.A = a; bus.RW = rw; bus.UDS = uds; bus.LDS = lds; bus.AS = 1'b0;
      for (int k = 0; k < 60 && ev_valid < 0; k++) begin
         tick();
         c = cmd_now();
         if (c == CMD_REF && ev_ref < 0) ev_ref = cyc;
         if (c == CMD_ACT && ev_act < 0) begin
            ev_act = cyc; ev_act_ma = bus.MA; ev_act_ba = bus.BA;
         end
         if ((c == CMD_RD || c == CMD_WR) && ev_cmd < 0) begin
            ev_cmd = cyc; ev_cmd_c = c; ev_cmd_ma = bus.MA; ev_cmd_ba = bus.BA;
            ev_cmd_dqm = bus.DQM;
         end
         if (!bus.VALID) begin
            ev_valid = cyc; ev_vdqm = bus.DQM;
         end
      end
      chk("valid_seen", 32'(ev_valid >= 0), 32'd1);
      for (int k = 0; k < hold; k++) begin
         tick();
         if (bus.VALID) ev_hold_ok = 1'b0;
      end
      bus.AS = 1'b1;
      tick();
      ev_rel = bus.VALID;
   endtask

   initial begin
      vec_t vt [6];
      int   w, t_act, t_rd, t_act2, n_r;
      int   rt [3];
      logic vlow, rd_seen;
      logic [2:0] c;

      vt[0] = '{23'h012345, 1'b1, 1'b0, 1'b0, 2, 2'd1, 13'h0024, 13'h0545, CMD_RD, 2'b00, CAS_LAT};
      vt[1] = '{23'h000000, 1'b0, 1'b1, 1'b0, 0, 2'd0, 13'h0000, 13'h0400, CMD_WR, 2'b10, 1};
      vt[2] = '{23'h7FFFFF, 1'b1, 1'b0, 1'b1, 1, 2'd3, 13'h0FFF, 13'h05FF, CMD_RD, 2'b01, CAS_LAT};
      vt[3] = '{23'h2AAAAA, 1'b0, 1'b0, 1'b0, 3, 2'd1, 13'h0555, 13'h04AA, CMD_WR, 2'b00, 1};
      vt[4] = '{23'h555555, 1'b1, 1'b1, 1'b1, 0, 2'd2, 13'h0AAA, 13'h0555, CMD_RD, 2'b11, CAS_LAT};
      vt[5] = '{23'h400201, 1'b0, 1'b0, 1'b1, 2, 2'd1, 13'h0800, 13'h0401, CMD_WR, 2'b01, 1};

      bus.AS = 1'b1; bus.RW = 1'b1; bus.UDS = 1'b1; bus.LDS = 1'b1; bus.A = 23'd0;
      run_init();

      // Locate the refresh-timer phase from an idle refresh.
      w = -1;
      for (int k = 0; k < 2 * REF_INTERVAL && w < 0; k++) begin
         tick();
         if (cmd_now() == CMD_REF) w = cyc;
      end
      chk("idle_ref_seen", 32'(w >= 0), 32'd1);

      // AS first sampled on the edge where the timer wraps: REF wins, ACT T_RFC later.
      while (cyc < w + REF_INTERVAL - 1 && cyc < w + 2 * REF_INTERVAL) tick();
      access(23'h0ABCDE, 1'b1, 1'b0, 1'b0, 1);
      chk("tie_ref_first", 32'(ev_ref), 32'(w + REF_INTERVAL));
      chk("tie_act_after_rfc", 32'(ev_act), 32'(w + REF_INTERVAL + T_RFC));
      repeat (4) tick();

      // Long hold: four wraps saturate pending at 3, then three REFs T_RFC apart.
      access(23'h001000, 1'b1, 1'b0, 1'b0, 4 * REF_INTERVAL);
      chk("sat_hold_valid_low", 32'(ev_hold_ok), 32'd1);
      n_r = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (cmd_now() == CMD_REF) begin
            if (n_r < 3) rt[n_r] = cyc;
            n_r++;
         end
      end
      chk("sat_ref_count", 32'(n_r), 32'd3);
      if (n_r >= 3) begin
         chk("sat_ref_gap1", 32'(rt[1] - rt[0]), 32'(T_RFC));
         chk("sat_ref_gap2", 32'(rt[2] - rt[1]), 32'(T_RFC));
      end

      for (int i = 0; i < 6; i++) begin
         access(vt[i].a, vt[i].rw, vt[i].uds, vt[i].lds, vt[i].hold);
         chk($sformatf("v%0d_act_row", i), 32'(ev_act_ma), 32'(vt[i].exp_row));
         chk($sformatf("v%0d_act_ba", i), 32'(ev_act_ba), 32'(vt[i].exp_ba));
         chk($sformatf("v%0d_cmd", i), 32'(ev_cmd_c), 32'(vt[i].exp_cmd));
         chk($sformatf("v%0d_col_ma", i), 32'(ev_cmd_ma), 32'(vt[i].exp_col));
         chk($sformatf("v%0d_cmd_ba", i), 32'(ev_cmd_ba), 32'(vt[i].exp_ba));
         chk($sformatf("v%0d_cmd_dqm", i), 32'(ev_cmd_dqm), 32'(vt[i].exp_dqm));
         chk($sformatf("v%0d_trcd", i), 32'(ev_cmd - ev_act), 32'(T_RCD));
         chk($sformatf("v%0d_latency", i), 32'(ev_valid - ev_cmd), 32'(vt[i].exp_lat));
         chk($sformatf("v%0d_valid_dqm", i), 32'(ev_vdqm),
             32'(vt[i].rw ? vt[i].exp_dqm : 2'b11));
         chk($sformatf("v%0d_hold", i), 32'(ev_hold_ok), 32'd1);
         chk($sformatf("v%0d_release", i), 32'(ev_rel), 32'd1);
         repeat (6) tick();
      end

      // Aborted accesses: AS high right after ACT, never a VALID pulse.
      bus.A = 23'h000100; bus.RW = 1'b1; bus.UDS = 1'b0; bus.LDS = 1'b0; bus.AS = 1'b0;
      t_act = -1; t_rd = -1; t_act2 = -1; vlow = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         c = cmd_now();
         if (!bus.VALID) vlow = 1'b1;
         if (c == CMD_ACT && t_act < 0) begin
            t_act = cyc; bus.AS = 1'b1;
         end else if (c == CMD_RD && t_rd < 0) begin
            t_rd = cyc; bus.AS = 1'b0;
         end else if (c == CMD_ACT && t_rd >= 0 && t_act2 < 0) begin
            t_act2 = cyc; bus.AS = 1'b1;
         end
      end
      chk("abort_no_valid", 32'(vlow), 32'd0);
      chk("abort_rd_issued", 32'(t_rd >= 0), 32'd1);
      chk("abort_next_act_trp", 32'((t_act2 >= 0) && (t_act2 - t_rd >= T_RP)), 32'd1);

      // Reset in the middle of a read.
      bus.A = 23'h012345; bus.RW = 1'b1; bus.AS = 1'b0;
      rd_seen = 1'b0;
      for (int k = 0; k < 30 && !rd_seen; k++) begin
         tick();
         if (cmd_now() == CMD_RD) rd_seen = 1'b1;
      end
      chk("midrd_rd_seen", 32'(rd_seen), 32'd1);
      RST = 1'b0;
      tick();
      chk("midrd_cmd_nop", 32'(cmd_now()), 32'(CMD_NOP));
      chk("midrd_cke", 32'(bus.CKE), 32'd0);
      chk("midrd_ready", 32'(bus.READY), 32'd0);
      chk("midrd_valid", 32'(bus.VALID), 32'd1);
      run_init();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
